// File: rtl/dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_arbiter
//  Description : Shares the single data memory between the pipeline MEM stage
//                (port 0, priority) and a secondary master (port 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_arbiter #(
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic        p0_wr,
   input  logic [1:0]  p0_nbytes,
   input  logic [15:0] p0_addr,
   input  logic [15:0] p0_wdata,
   output logic        p0_done,
   output logic [15:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_wr,
   input  logic [1:0]  p1_nbytes,
   input  logic [15:0] p1_addr,
   input  logic [15:0] p1_wdata,
   output logic        p1_done,
   output logic [15:0] p1_rdata,
   output logic        stall,
   output logic        mem_rd_en,
   output logic        mem_wr_en,
   output logic [1:0]  mem_nbytes,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   localparam logic [3:0] c_lat_load = MEM_LATENCY[3:0];
   localparam logic [3:0] c_starve   = STARVE_LIMIT[3:0];

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_owner;
   logic        r_cmd_wr;
   logic [1:0]  r_cmd_nbytes;
   logic [15:0] r_cmd_addr;
   logic [15:0] r_cmd_wdata;
   logic [3:0]  r_lat_cnt;
   logic [3:0]  r_starve_cnt;
   logic [15:0] r_p0_rdata;
   logic [15:0] r_p1_rdata;

   logic        w_any_req;
   logic        w_grant_p1;
   logic        w_start;
   logic        w_last;

   assign w_any_req  = p0_req | p1_req;
   // Port 1 wins only when alone or when port 0 has starved it long enough.
   assign w_grant_p1 = p1_req & (~p0_req | (r_starve_cnt == c_starve));
   assign w_start    = (r_state == S_IDLE) & w_any_req;
   assign w_last     = (r_state == S_ACCESS) & (r_lat_cnt == 4'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
         S_ACCESS: if (w_last)    w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_owner      <= 1'b0;
         r_cmd_wr     <= 1'b0;
         r_cmd_nbytes <= 2'b00;
         r_cmd_addr   <= 16'h0000;
         r_cmd_wdata  <= 16'h0000;
         r_lat_cnt    <= 4'd0;
         r_starve_cnt <= 4'd0;
         r_p0_rdata   <= 16'h0000;
         r_p1_rdata   <= 16'h0000;
      end else if (w_start) begin
         r_owner   <= w_grant_p1;
         r_lat_cnt <= c_lat_load;
         if (w_grant_p1) begin
            r_cmd_wr     <= p1_wr;
            r_cmd_nbytes <= p1_nbytes;
            r_cmd_addr   <= p1_addr;
            r_cmd_wdata  <= p1_wdata;
            r_starve_cnt <= 4'd0;
         end else begin
            r_cmd_wr     <= p0_wr;
            r_cmd_nbytes <= p0_nbytes;
            r_cmd_addr   <= p0_addr;
            r_cmd_wdata  <= p0_wdata;
            if (!p1_req) begin
               r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt != c_starve) begin
               r_starve_cnt <= r_starve_cnt + 4'd1;
            end
         end
      end else if (r_state == S_ACCESS) begin
         r_lat_cnt <= r_lat_cnt - 4'd1;
         // Read data is only trusted on the final held cycle.
         if (w_last && !r_cmd_wr) begin
            if (r_owner) begin
               r_p1_rdata <= mem_rdata;
            end else begin
               r_p0_rdata <= mem_rdata;
            end
         end
      end
   end

   // A write strobes once, on the cycle the counter still holds its load value.
   assign mem_rd_en  = (r_state == S_ACCESS) & ~r_cmd_wr;
   assign mem_wr_en  = (r_state == S_ACCESS) & r_cmd_wr & (r_lat_cnt == c_lat_load);
   assign mem_nbytes = r_cmd_nbytes;
   assign mem_addr   = r_cmd_addr;
   assign mem_wdata  = r_cmd_wdata;

   assign p0_done  = (r_state == S_DONE) & ~r_owner;
   assign p1_done  = (r_state == S_DONE) & r_owner;
   assign p0_rdata = r_p0_rdata;
   assign p1_rdata = r_p1_rdata;
   assign stall    = p0_req & ~p0_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_arbiter
//  Description : Two arbiter instances (latency 1 and 3) checked against a
//                transaction-age model every cycle plus directed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_access_arbiter;

   localparam int c_starve = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst_n, p0_req, p0_wr, p1_req, p1_wr;
   logic [1:0][1:0]  p0_nbytes, p1_nbytes;
   logic [1:0][15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   wire  [1:0]       p0_done, p1_done, stall, mem_rd_en, mem_wr_en;
   wire  [1:0][1:0]  mem_nbytes;
   wire  [1:0][15:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      case (a)
         16'h0010: return 16'hBEEF;
         16'h0002: return 16'h1111;
         16'h0004: return 16'h2222;
         default:  return a ^ 16'h5A5A;
      endcase
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   for (genvar i = 0; i < 2; i++) begin : g_dut
      assign mem_rdata[i] = mem_fn(mem_addr[i]);
      dmem_access_arbiter #(.MEM_LATENCY((i == 0) ? 1 : 3), .STARVE_LIMIT(4)) u_dut (
         .clk(clk), .rst_n(rst_n[i]),
         .p0_req(p0_req[i]), .p0_wr(p0_wr[i]), .p0_nbytes(p0_nbytes[i]),
         .p0_addr(p0_addr[i]), .p0_wdata(p0_wdata[i]),
         .p0_done(p0_done[i]), .p0_rdata(p0_rdata[i]),
         .p1_req(p1_req[i]), .p1_wr(p1_wr[i]), .p1_nbytes(p1_nbytes[i]),
         .p1_addr(p1_addr[i]), .p1_wdata(p1_wdata[i]),
         .p1_done(p1_done[i]), .p1_rdata(p1_rdata[i]),
         .stall(stall[i]), .mem_rd_en(mem_rd_en[i]), .mem_wr_en(mem_wr_en[i]),
         .mem_nbytes(mem_nbytes[i]), .mem_addr(mem_addr[i]),
         .mem_wdata(mem_wdata[i]), .mem_rdata(mem_rdata[i])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: a transaction is just its owner, command and age since grant.
   bit          m_busy [2];
   bit          m_owner[2];
   int          m_age  [2];
   int          m_starve[2];
   logic        m_wr   [2];
   logic [1:0]  m_nb   [2];
   logic [15:0] m_addr [2];
   logic [15:0] m_wdata[2];
   logic [15:0] m_rd0  [2];
   logic [15:0] m_rd1  [2];

   always @(posedge clk) begin
      int  lat;
      bit  g1;
      cyc++;
      for (int k = 0; k < 2; k++) begin
         lat = lat_of(k);
         if (!rst_n[k]) begin
            m_busy[k] = 0; m_owner[k] = 0; m_age[k] = 0; m_starve[k] = 0;
            m_wr[k] = 0; m_nb[k] = 0; m_addr[k] = 0; m_wdata[k] = 0;
            m_rd0[k] = 0; m_rd1[k] = 0;
         end else if (m_busy[k]) begin
            if (m_age[k] == lat + 1) begin
               m_busy[k] = 0;
            end else begin
               m_age[k]++;
               if (m_age[k] == lat + 1 && !m_wr[k]) begin
                  if (m_owner[k]) m_rd1[k] = mem_fn(m_addr[k]);
                  else            m_rd0[k] = mem_fn(m_addr[k]);
               end
            end
         end else if (p0_req[k] || p1_req[k]) begin
            g1 = p1_req[k] && (!p0_req[k] || m_starve[k] == c_starve);
            m_owner[k] = g1;
            if (g1) begin
               m_wr[k] = p1_wr[k]; m_nb[k] = p1_nbytes[k];
               m_addr[k] = p1_addr[k]; m_wdata[k] = p1_wdata[k];
               m_starve[k] = 0;
            end else begin
               m_wr[k] = p0_wr[k]; m_nb[k] = p0_nbytes[k];
               m_addr[k] = p0_addr[k]; m_wdata[k] = p0_wdata[k];
               m_starve[k] = !p1_req[k] ? 0 :
                             (m_starve[k] == c_starve) ? c_starve : m_starve[k] + 1;
            end
            m_busy[k] = 1;
            m_age[k]  = 1;
         end
      end
   end

   int rd_cnt[2], wr_cnt[2], d0_cnt[2], d1_cnt[2], st_cnt[2];
   int glog[$];

   task automatic clear_counts();
      for (int k = 0; k < 2; k++) begin
         rd_cnt[k] = 0; wr_cnt[k] = 0; d0_cnt[k] = 0; d1_cnt[k] = 0; st_cnt[k] = 0;
      end
      glog.delete();
   endtask

   always @(negedge clk) begin
      int   lat;
      logic e_d0, e_d1, e_rd, e_wr, e_st;
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            lat  = lat_of(k);
            e_d0 = m_busy[k] && m_age[k] == lat + 1 && !m_owner[k];
            e_d1 = m_busy[k] && m_age[k] == lat + 1 && m_owner[k];
            e_rd = m_busy[k] && m_age[k] <= lat && !m_wr[k];
            e_wr = m_busy[k] && m_age[k] == 1 && m_wr[k];
            e_st = p0_req[k] && !e_d0;
            check($sformatf("cycle_dut%0d", k),
                  {9'd0, p0_done[k], p1_done[k], stall[k], mem_rd_en[k], mem_wr_en[k],
                   mem_nbytes[k], mem_addr[k], mem_wdata[k], p0_rdata[k], p1_rdata[k]},
                  {9'd0, e_d0, e_d1, e_st, e_rd, e_wr,
                   m_nb[k], m_addr[k], m_wdata[k], m_rd0[k], m_rd1[k]});
            if (mem_rd_en[k] === 1'b1) rd_cnt[k]++;
            if (mem_wr_en[k] === 1'b1) wr_cnt[k]++;
            if (stall[k] === 1'b1)     st_cnt[k]++;
            if (p0_done[k] === 1'b1) begin d0_cnt[k]++; if (k == 1) glog.push_back(0); end
            if (p1_done[k] === 1'b1) begin d1_cnt[k]++; if (k == 1) glog.push_back(1); end
         end
      end
   end

   // Called just after a rising edge; returns cycles from raising req to done.
   task automatic txn(input int k, input int port, input logic wr, input logic [1:0] nb,
                      input logic [15:0] addr, input logic [15:0] wdata, output int lat_cyc);
      int start;
      if (port == 0) begin
         p0_wr[k] = wr; p0_nbytes[k] = nb; p0_addr[k] = addr; p0_wdata[k] = wdata; p0_req[k] = 1'b1;
      end else begin
         p1_wr[k] = wr; p1_nbytes[k] = nb; p1_addr[k] = addr; p1_wdata[k] = wdata; p1_req[k] = 1'b1;
      end
      start   = cyc;
      lat_cyc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (((port == 0) ? p0_done[k] : p1_done[k]) === 1'b1) begin
            lat_cyc = cyc - start;
            break;
         end
      end
      @(posedge clk); #1;
      if (port == 0) p0_req[k] = 1'b0; else p1_req[k] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int la, lb, ls;
      rst_n = '0; p0_req = '0; p1_req = '0; p0_wr = '0; p1_wr = '0;
      p0_nbytes = '0; p1_nbytes = '0; p0_addr = '0; p1_addr = '0;
      p0_wdata = '0; p1_wdata = '0;
      clear_counts();
      @(posedge clk); #1 chk_on = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++)
         check($sformatf("reset_outputs_dut%0d", k),
               {9'd0, p0_done[k], p1_done[k], stall[k], mem_rd_en[k], mem_wr_en[k],
                mem_nbytes[k], mem_addr[k], mem_wdata[k], p0_rdata[k], p1_rdata[k]}, 80'd0);
      @(posedge clk); #1 rst_n = 2'b11;
      @(posedge clk); #1;

      // Single read, latency 1
      clear_counts();
      txn(0, 0, 1'b0, 2'b10, 16'h0010, 16'h0000, la);
      check("read_l1_latency", la, 2);
      check("read_l1_rdata", p0_rdata[0], 16'hBEEF);
      check("read_l1_rd_cycles", rd_cnt[0], 1);
      check("read_l1_stall_cycles", st_cnt[0], 2);

      // Write, latency 3
      clear_counts();
      txn(1, 1, 1'b1, 2'b01, 16'h0020, 16'h1234, la);
      check("write_l3_latency", la, 4);
      check("write_l3_wr_pulses", wr_cnt[1], 1);
      check("write_l3_rd_cycles", rd_cnt[1], 0);
      check("write_l3_p1_rdata", p1_rdata[1], 16'h0000);
      check("write_l3_held_cmd", {mem_nbytes[1], mem_addr[1], mem_wdata[1]},
            {2'b01, 16'h0020, 16'h1234});

      // Simultaneous requests
      clear_counts();
      fork
         txn(1, 0, 1'b0, 2'b10, 16'h0002, 16'h0000, la);
         txn(1, 1, 1'b0, 2'b10, 16'h0004, 16'h0000, lb);
      join
      check("simul_p0_latency", la, 4);
      check("simul_p1_latency", lb, 9);
      check("simul_order", {glog.size(), glog[0], glog[1]}, {32'd2, 32'd0, 32'd1});
      check("simul_p0_rdata", p0_rdata[1], 16'h1111);
      check("simul_p1_rdata", p1_rdata[1], 16'h2222);

      // Starvation: p0 continuous, p1 held
      clear_counts();
      fork
         begin
            for (int i = 0; i < 5; i++) txn(1, 0, 1'b0, 2'b10, 16'h0040 + 16'(i), 16'h0000, ls);
         end
         txn(1, 1, 1'b0, 2'b10, 16'h0044, 16'h0000, lb);
      join
      check("starve_grant_count", glog.size(), 6);
      if (glog.size() == 6)
         check("starve_order", {glog[0][7:0], glog[1][7:0], glog[2][7:0], glog[3][7:0],
                                glog[4][7:0], glog[5][7:0]}, 48'h00_00_00_00_01_00);
      check("starve_p1_latency", lb, 4 * 5 + 4);
      check("starve_p1_rdata", p1_rdata[1], 16'h0044 ^ 16'h5A5A);

      // Request withdrawn during ACCESS
      clear_counts();
      p0_wr[1] = 1'b0; p0_nbytes[1] = 2'b10; p0_addr[1] = 16'h0010; p0_req[1] = 1'b1;
      @(posedge clk); #1 p0_req[1] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("withdraw_done_pulses", d0_cnt[1], 1);
      check("withdraw_stall_cycles", st_cnt[1], 1);
      check("withdraw_rdata", p0_rdata[1], 16'hBEEF);

      // Reset mid-ACCESS of a p1 write
      p1_wr[1] = 1'b1; p1_nbytes[1] = 2'b11; p1_addr[1] = 16'h0030; p1_wdata[1] = 16'h5555;
      p1_req[1] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n[1] = 1'b0; p1_req[1] = 1'b0;
      clear_counts();
      @(posedge clk); #1 rst_n[1] = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("reset_no_wr", wr_cnt[1], 0);
      check("reset_no_done", d1_cnt[1] + d0_cnt[1], 0);
      check("reset_after_outputs",
            {9'd0, p0_done[1], p1_done[1], stall[1], mem_rd_en[1], mem_wr_en[1],
             mem_nbytes[1], mem_addr[1], mem_wdata[1], p0_rdata[1], p1_rdata[1]}, 80'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Sequences and shares the single data memory between two requesters.
- Port 0 is the pipeline MEM stage and has priority.
- Port 1 is a secondary master, such as a program/data loader or debug port.
- The block owns every data-memory control line (read enable, write enable, byte count, address, write data), captures read data, and stalls the pipeline while a port-0 access is outstanding.

Parameters:
- MEM_LATENCY, 1: cycles the memory control lines are held before read data is valid (1..15).
- STARVE_LIMIT, 4: consecutive port-0 grants while port 1 waits before port 1 is forced through (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- p0_req  in  1  port 0 request; held until p0_done
- p0_wr  in  1  1 = write, 0 = read
- p0_nbytes  in  2  byte count, same encoding as the memory's byte-count field
- p0_addr  in  16  byte address
- p0_wdata  in  16  write data
- p0_done  out  1  one-cycle completion pulse
- p0_rdata  out  16  read data, valid while p0_done is high
- p1_req, p1_wr, p1_nbytes, p1_addr, p1_wdata, p1_done, p1_rdata: same as port 0, for port 1
- stall  out  1  pipeline hold = p0_req & ~p0_done (combinational)
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_nbytes  out  2  memory byte count
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data

Behaviour:
- Reset:
  - rst_n low at a rising edge → state IDLE.
  - All outputs 0 except stall, which follows its equation; p0_rdata/p1_rdata = 16'h0000.
  - Starvation counter = 0, latency counter = 0.
  - Reset mid-ACCESS/DONE abandons the transaction: no done pulse, enables low from the next cycle.
- States:
  - IDLE: sample requests.
    - Neither port requesting → stay.
    - Otherwise select owner, latch owner's wr/nbytes/addr/wdata into a command register, load the latency counter with MEM_LATENCY, go ACCESS.
  - ACCESS: drive the mem_* outputs from the command register.
    - Read: mem_rd_en high for all MEM_LATENCY cycles.
    - Write: mem_wr_en high in the first ACCESS cycle only, so exactly one write occurs.
    - Counter decrements each cycle. On the last cycle (counter = 1), a read captures mem_rdata into the owner's rdata register; a write leaves rdata unchanged. Go DONE.
  - DONE: owner's done = 1 for exactly this cycle; all mem enables 0; go IDLE. No request sampling in DONE.
- Timing:
  - Request first sampled at edge N → ACCESS for cycles N+1 .. N+MEM_LATENCY → done high in cycle N+MEM_LATENCY+1.
  - Back-to-back transactions are MEM_LATENCY+2 cycles apart.
- Arbitration (IDLE only):
  - Only one port requesting → that port.
  - Both requesting → port 0, unless the starvation counter = STARVE_LIMIT, in which case port 1.
- Starvation counter:
  - +1 when port 0 is granted while p1_req = 1, saturating at STARVE_LIMIT.
  - Cleared when port 1 is granted, or when port 0 is granted with p1_req = 0.
- Handshake rules:
  - Requester holds req and command stable until its done and drops req at the edge ending the done cycle.
  - Dropping req or changing the command mid-transaction does not affect the transaction; the latched command completes and done still pulses.
- mem_nbytes, mem_addr, mem_wdata:
  - Forwarded unmodified from the latched command; no alignment checks.
  - Held at the last command value outside ACCESS.
  - Only the enables are forced low outside ACCESS.
- rdata registers hold their value until the next read completes for that port.
- stall is combinational and goes low in the same cycle p0_done is high.

Test Plan:
- Reset: assert rst_n = 0 mid-ACCESS of a p1 write → no further mem_wr_en, no p1_done; after release all outputs 0, state IDLE.
- Single read, MEM_LATENCY = 1: p0 read, addr 16'h0010, mem_rdata model returns 16'hBEEF → mem_rd_en high 1 cycle, p0_done in cycle 2 after first sample, p0_rdata = 16'hBEEF; stall high 2 cycles.
- Write, MEM_LATENCY = 3: p1 write, addr 16'h0020, wdata 16'h1234, nbytes 2'b01 → mem_wr_en high exactly 1 cycle; mem_addr/mem_wdata/mem_nbytes stable 3 cycles; p1_done 4 cycles after first sample; p1_rdata unchanged.
- Simultaneous requests: both request in the same cycle, p0 reads 16'h0002, p1 reads 16'h0004 → p0 served first; p1 granted in the next IDLE; starvation counter ends at 0.
- Starvation, STARVE_LIMIT = 4: p0 requests continuously, p1 held high → p0 granted 4 times, 5th grant to p1, then p0 resumes.
- Request withdrawn: p0 drops req during ACCESS → transaction completes; p0_done still pulses once; stall low after the drop.
